audio_pll_reset_seq: RTL and testbench

AUDIO_PLL_RESET_SEQ -- requirements
Module: audio_pll_reset_seq

---
 rtl/audio_pll_pkg.sv | 14 +
 rtl/audio_pll_lock_sync.sv | 21 ++
 rtl/audio_pll_reset_seq.sv | 143 ++++++++++++++
 tb/tb_audio_pll_reset_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pll_pkg.sv
// audio_pll_pkg: FSM state type and relock counter width for the audio PLL reset sequencer
// AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN adds the FAULT state to the enum.
package audio_pll_pkg;
    localparam int RELOCK_W = 8;
    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN
`ifdef AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN
        , FAULT
`endif
    } pll_state_e;
endpackage

// File: rtl/audio_pll_lock_sync.sv
// audio_pll_lock_sync: two-flop synchronizer bringing pll_locked into the refclk domain
module audio_pll_lock_sync (
    input  logic refclk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);
    logic meta_q;
    logic sync_q;
    // Two back-to-back flops, both cleared by rst so lock reads as lost after reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end
    assign sync_out = sync_q;
endmodule

// File: rtl/audio_pll_reset_seq.sv
// audio_pll_reset_seq: PLL reset/lock sequencer; AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN enables the retry limit and FAULT state
module audio_pll_reset_seq
    import audio_pll_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                relock_req,
    output logic                pll_rst,
    output logic                domain_rst,
    output logic                ready,
    output logic                fault,
    output logic [RELOCK_W-1:0] relock_count
);
    localparam int MAX_CYC = (RST_CYCLES > LOCK_TIMEOUT)
        ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
        : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int CW = $clog2(MAX_CYC);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

    if (RST_CYCLES < 2 || MAX_RETRIES < 1) begin : g_bad_param
        $error("audio_pll_reset_seq: RST_CYCLES must be >= 2 and MAX_RETRIES >= 1");
    end

    logic locked_s;
    logic restart;
    pll_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic pll_rst_q, pll_rst_d;
    logic domain_rst_q, domain_rst_d;
    logic ready_q, ready_d;
`ifdef AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN
    localparam int RW = $clog2(MAX_RETRIES + 1);
    logic [RW-1:0] retries_q, retries_d;
    logic fault_q, fault_d;
`endif

    audio_pll_lock_sync u_lock_sync (
        .refclk   (refclk),
        .rst      (rst),
        .async_in (pll_locked),
        .sync_out (locked_s)
    );

    // Next state, counters, and outputs decoded from the next state so they line up with it.
    always_comb begin
        state_d  = state_q;
        relock_d = relock_q;
        restart  = 1'b0;
`ifdef AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN
        retries_d = retries_q;
`endif
        case (state_q)
            RESET_PLL: begin
                restart = relock_req;
                state_d = (!relock_req && cnt_q == RST_LAST) ? WAIT_LOCK : RESET_PLL;
            end
            WAIT_LOCK: begin
                if (relock_req) state_d = RESET_PLL;
                else if (locked_s) state_d = STABLE;
                else if (cnt_q == LOCK_LAST) begin
`ifdef AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN
                    state_d   = (retries_q == RW'(MAX_RETRIES - 1)) ? FAULT : RESET_PLL;
                    retries_d = retries_q + 1'b1;
`else
                    state_d = RESET_PLL;
`endif
                end
            end
            STABLE: begin
                if (relock_req) state_d = RESET_PLL;
                else if (!locked_s) state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
`ifdef AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN
                    retries_d = '0;
`endif
                end
            end
            RUN: begin
                if (relock_req || !locked_s) begin
                    state_d  = RESET_PLL;
                    relock_d = (&relock_q) ? relock_q : relock_q + 1'b1;
                end
            end
            default: state_d = state_q;
        endcase
        cnt_d        = (restart || state_d != state_q) ? '0 : cnt_q + 1'b1;
        domain_rst_d = state_d != RUN;
        ready_d      = state_d == RUN;
`ifdef AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN
        fault_d   = state_d == FAULT;
        pll_rst_d = state_d == RESET_PLL || fault_d;
`else
        pll_rst_d = state_d == RESET_PLL;
`endif
    end

    // State and registered outputs; rst forces the PLL back into reset with counters cleared.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= RESET_PLL;
            cnt_q        <= '0;
            relock_q     <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= 1'b1;
            ready_q      <= 1'b0;
`ifdef AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN
            retries_q    <= '0;
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            relock_q     <= relock_d;
            pll_rst_q    <= pll_rst_d;
            domain_rst_q <= domain_rst_d;
            ready_q      <= ready_d;
`ifdef AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN
            retries_q    <= retries_d;
            fault_q      <= fault_d;
`endif
        end
    end

    assign pll_rst      = pll_rst_q;
    assign domain_rst   = domain_rst_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;
`ifdef AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_audio_pll_reset_seq.sv
// tb_audio_pll_reset_seq: directed self-checking bench for audio_pll_reset_seq
module tb_audio_pll_reset_seq;
    localparam int RST_C  = 4;
    localparam int LOCK_T = 20;
    localparam int STAB_C = 8;
    localparam int MAX_R  = 3;
    localparam int PERIOD = RST_C + LOCK_T;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       domain_rst;
    logic       ready;
    logic       fault;
    logic [7:0] relock_count;
    int n_checks = 0;
    int n_fail = 0;

    audio_pll_reset_seq #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (LOCK_T),
        .STABLE_CYCLES (STAB_C),
        .MAX_RETRIES   (MAX_R)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .domain_rst   (domain_rst),
        .ready        (ready),
        .fault        (fault),
        .relock_count (relock_count)
    );

    always #5 refclk = ~refclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Counts samples with pll_rst high, starting from the current one.
    task automatic count_high(output int n);
        n = 0;
        while (pll_rst && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic count_to_ready(output int n, output int rst_seen);
        n = 0;
        rst_seen = 0;
        while (!ready && n < 100) begin
            n++;
            step();
            if (pll_rst) rst_seen = 1;
        end
    endtask

    // PLL model: lock is lost as the sequence starts and returns once pll_rst falls.
    task automatic relock_cycle(input bit use_req, output int hi, output int rdy);
        int w;
        int seen;
        w = 0;
        pll_locked = 1'b0;
        relock_req = use_req;
        step();
        relock_req = 1'b0;
        while (!pll_rst && w < 20) begin
            w++;
            step();
        end
        count_high(hi);
        pll_locked = 1'b1;
        count_to_ready(rdy, seen);
    endtask

    initial begin
        int hi;
        int rdy;
        int seen;
        int errs;
        logic exp_rst;
        logic exp_fault;
        step();
        step();
        check("reset_pll_rst", pll_rst, 1);
        check("reset_domain_rst", domain_rst, 1);
        check("reset_ready", ready, 0);
        check("reset_fault", fault, 0);
        check("reset_relock_count", relock_count, 0);
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        check("rst_over_relock_pll_rst", pll_rst, 1);
        rst = 1'b0;
        count_high(hi);
        check("release_pll_rst_width", hi, RST_C);
        pll_locked = 1'b1;
        count_to_ready(rdy, seen);
        // reset + one WAIT_LOCK cycle + synchronizer + stable window, from rst release
        check("release_to_ready", hi + rdy, RST_C + 1 + 2 + STAB_C);
        check("run_domain_rst", domain_rst, 0);
        check("run_relock_count", relock_count, 0);

        do_reset();
        count_high(hi);
        pll_locked = 1'b1;
        repeat (5) step();
        check("stable_not_ready", ready, 0);
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        count_to_ready(rdy, seen);
        // glitch reaches the FSM 2 cycles later, 1 cycle in WAIT_LOCK, then a full window
        check("glitch_to_ready", rdy, 2 + 1 + STAB_C);
        check("glitch_no_pll_rst", seen, 0);

        relock_cycle(1'b1, hi, rdy);
        check("relock_pll_rst_width", hi, RST_C);
        check("relock_count_1", relock_count, 1);
        check("relock_to_ready", rdy, 1 + 2 + STAB_C);
        relock_cycle(1'b0, hi, rdy);
        check("lockloss_pll_rst_width", hi, RST_C);
        check("lockloss_count_2", relock_count, 2);
        for (int i = 1; i <= 298; i++) begin
            relock_cycle(1'b1, hi, rdy);
            if (i == 252) check("relock_count_254", relock_count, 254);
        end
        check("relock_count_sat", relock_count, 255);

        pll_locked = 1'b0;
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        check("relock_count_sat_hold", relock_count, 255);
        count_high(hi);
        repeat (5) step();
        check("mid_wait_pll_rst", pll_rst, 0);
        rst = 1'b1;
        step();
        check("midrst_pll_rst", pll_rst, 1);
        check("midrst_domain_rst", domain_rst, 1);
        check("midrst_relock_count", relock_count, 0);
        rst = 1'b0;
        count_high(hi);
        check("midrst_pll_rst_width", hi, RST_C);

        do_reset();
        errs = 0;
        for (int k = 0; k < 200; k++) begin
            exp_rst = (k % PERIOD) < RST_C;
            exp_fault = 1'b0;
`ifdef AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN
            if (k >= MAX_R * PERIOD) begin
                exp_rst = 1'b1;
                exp_fault = 1'b1;
            end
`endif
            if (pll_rst !== exp_rst || fault !== exp_fault) errs++;
            step();
        end
        check("timeout_pattern_errs", errs, 0);
`ifdef AUDIO_PLL_RESET_SEQ_RETRY_LIMIT_EN
        check("fault_set", fault, 1);
        relock_req = 1'b1;
        step();
        relock_req = 1'b0;
        step();
        check("fault_ignores_relock", fault, 1);
        check("fault_pll_rst", pll_rst, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("fault_cleared_by_rst", fault, 0);
        check("fault_rst_pll_rst", pll_rst, 1);
`else
        check("no_fault", fault, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
